seven_seg_scanner: RTL
======================

# seven_seg_scanner

Parametrised, time-multiplexed driver for a common-anode seven-segment display with DIGITS digits. It captures a packed hexadecimal value with per-digit decimal points and blank masks, then scans one digit at a time. For each digit it drives one-cold active-low anodes and active-low segment patterns. It replaces the fixed 2:4 anode decoder in the board top level with a self-scanning block that adds hex decode, blanking, leading-zero suppression and a refresh prescaler.

## Interface
- DIGITS, 4, number of digits/anodes; legal range 2..8
- PRESCALE, 100000, clock cycles per digit slot; legal range ≥1 (100000 gives a 1 kHz slot rate at 100 MHz)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  scan enable; low holds the prescaler and blanks the display
- load  in  1  one-cycle strobe; captures value, dp, blank and lzs into shadow registers
- value  in  4*DIGITS  packed nibbles; nibble k (bits 4k+3:4k) is digit k, digit 0 is rightmost
- dp  in  DIGITS  decimal point request per digit, 1 = lit
- blank  in  DIGITS  per-digit forced blank, 1 = digit dark
- lzs  in  1  leading-zero suppression enable
- AN  out  DIGITS  anode enables, active-low, at most one low at any time
- SEG  out  7  segments, active-low, SEG[0]=a … SEG[6]=g
- DP  out  1  decimal point, active-low

## Operation
- Shadow registers (value, dp, blank, lzs) reset to 0. They load only on load=1, independent of en. The display shows only shadow contents, never live inputs.
- Prescaler counts 0..PRESCALE-1 while en=1, holds while en=0. tick = en ∧ (count == PRESCALE-1). On tick, count→0 and digit index idx→idx+1, wrapping DIGITS-1→0.
- Digit k is suppressed when lzs_shadow=1, k≥1, and nibbles k..DIGITS-1 are all zero. Digit 0 is never suppressed.
- Digit k is dark when blank_shadow[k]=1, or k is suppressed, or en=0. Dark means AN all ones, SEG=7'h7F, DP=1.
- Otherwise AN has only bit idx low. SEG is the active-low hex decode of nibble idx. DP = ~dp_shadow[idx].
- Hex decode, values shown as {g..a} in hex: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- No FSM beyond the idx counter. idx width is clog2(DIGITS). Values of idx ≥ DIGITS are unreachable and must decode as dark.

## Timing
- Reset values: count=0, idx=0, shadow=0, AN all ones, SEG=7'h7F, DP=1.
- AN, SEG and DP are registered, computed each cycle from the current idx, shadow and en. Outputs therefore lag an idx change or a load by exactly 1 cycle.
- With en=1 from the first cycle after reset: AN shows digit 0 one cycle after reset deasserts. Each digit is then active for exactly PRESCALE cycles. A full refresh takes DIGITS*PRESCALE cycles.
- load coincident with tick: the shadow updates and idx advances on the same edge. The following cycle's outputs reflect the new shadow at the new idx.
- en falling: outputs go dark 1 cycle later; count and idx freeze. en rising resumes from the frozen count/idx.
- PRESCALE=1: idx advances every enabled cycle.
- rst mid-scan: all state returns to reset values on that edge, regardless of en/load. A load coincident with rst is discarded.
- No glitch requirement beyond registered outputs. The anode and segment registers switch on the same edge.

## Test plan
- Reset then DIGITS=4, PRESCALE=3, en=1, load value=16'h12AF, dp=0, blank=0 → AN cycles E,D,B,7 (3 cycles each) with SEG 0E,08,24,79.
- dp=4'b0100, blank=4'b1000, value=16'h8888 → digit 2 has DP=0; during the digit 3 slot AN=F, SEG=7F. idx still advances on schedule.
- lzs=1, value=16'h0050 → digits 3 and 2 dark, digit 1 SEG=12, digit 0 SEG=40. Then value=16'h0000 → only digit 0 lit, showing 40.
- en low for 10 cycles mid-slot → AN=F one cycle later, idx/count frozen. On resume the current slot completes its remaining cycles.
- load asserted on a tick edge with value changed 1234→5678 → the next digit shows the new nibble. Also check PRESCALE=1 and DIGITS=8: idx wraps 7→0.
- rst asserted mid-scan together with load → AN=FF…, SEG=7F, shadow=0. After release, digit 0 shows 40.

Source files
------------

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: bundles the display request and drive signals of
// seven_seg_scanner.
//   master : en, load, value, dp, blank, lzs out; AN, SEG, DP in
//   slave  : the scanner itself (inverse directions)
// value packs one nibble per digit, digit 0 in bits 3:0. AN, SEG and DP are
// active-low (common-anode display), SEG[0]=a .. SEG[6]=g.
interface seven_seg_scanner_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     blank;
  logic                  lzs;
  logic [DIGITS-1:0]     AN;
  logic [6:0]            SEG;
  logic                  DP;

  modport master (
    output en, load, value, dp, blank, lzs,
    input  AN, SEG, DP
  );

  modport slave (
    input  en, load, value, dp, blank, lzs,
    output AN, SEG, DP
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed common-anode seven-segment driver.
// Captures value/dp/blank/lzs into shadow registers on load, then scans one
// digit per PRESCALE enabled cycles, with hex decode, per-digit blanking and
// leading-zero suppression. All outputs are registered.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : seven_seg_scanner_if slave (request inputs, AN/SEG/DP outputs)
module seven_seg_scanner #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 100000
) (
  input logic                clk,
  input logic                rst,
  seven_seg_scanner_if.slave bus
);
  localparam int unsigned   IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned   CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   blank_q;
  logic                lzs_q;

  logic [CW-1:0]       count_q, count_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                tick;

  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_out_q, dp_out_d;

  logic [3:0]          sel_nib;
  logic                sel_dp;
  logic                sel_blank;
  logic                sel_valid;
  logic                upper_zero;
  logic                suppressed;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Prescaler and digit index; both freeze while en is low.
  always_comb begin
    tick    = bus.en && (count_q == CNT_LAST);
    count_d = count_q;
    idx_d   = idx_q;
    if (tick) begin
      count_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else if (bus.en) begin
      count_d = count_q + 1'b1;
    end
  end

  // Output decode for the current idx. An idx outside 0..DIGITS-1 never
  // matches the select loop, so sel_valid stays low and the display is dark.
  always_comb begin
    an_d       = '1;
    seg_d      = 7'h7F;
    dp_out_d   = 1'b1;
    sel_nib    = 4'h0;
    sel_dp     = 1'b0;
    sel_blank  = 1'b1;
    sel_valid  = 1'b0;
    upper_zero = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        sel_valid = 1'b1;
        sel_nib   = value_q[4*k +: 4];
        sel_dp    = dp_q[k];
        sel_blank = blank_q[k];
      end
      // Suppression needs this digit and every more significant one zero.
      if ((k >= 32'(idx_q)) && (value_q[4*k +: 4] != 4'h0))
        upper_zero = 1'b0;
    end
    suppressed = lzs_q && (idx_q != '0) && upper_zero;
    if (bus.en && sel_valid && !sel_blank && !suppressed) begin
      an_d     = ~(DIGITS'(1) << idx_q);
      seg_d    = hex7(sel_nib);
      dp_out_d = ~sel_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= '0;
      dp_q     <= '0;
      blank_q  <= '0;
      lzs_q    <= 1'b0;
      count_q  <= '0;
      idx_q    <= '0;
      an_q     <= '1;
      seg_q    <= 7'h7F;
      dp_out_q <= 1'b1;
    end else begin
      if (bus.load) begin
        value_q <= bus.value;
        dp_q    <= bus.dp;
        blank_q <= bus.blank;
        lzs_q   <= bus.lzs;
      end
      count_q  <= count_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_out_q <= dp_out_d;
    end
  end

  assign bus.AN  = an_q;
  assign bus.SEG = seg_q;
  assign bus.DP  = dp_out_q;
endmodule
